// File: rtl/register_pipe_ctrl_pkg.sv
// Shared definitions for the register_pipe_ctrl valid/ready stage chain.
// Optional stall statistics are enabled by defining REGISTER_PIPE_CTRL_STATS_EN.
package register_pipe_ctrl_pkg;

    localparam int          MIN_STAGES  = 1;
    localparam string       STATS_MACRO = "REGISTER_PIPE_CTRL_STATS_EN";
    localparam logic [31:0] STALL_MAX   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OCC_HOLD,
        OCC_INC,
        OCC_DEC
    } occ_op_e;

    // Simultaneous accept on both ends leaves the occupancy where it is.
    function automatic occ_op_e occ_op(input logic in_acc, input logic out_acc);
        occ_op_e op;
        op = OCC_HOLD;
        if (in_acc && !out_acc) begin
            op = OCC_INC;
        end else if (!in_acc && out_acc) begin
            op = OCC_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/register_pipe_stage.sv
// One datapath register stage: WIDTH-bit data plus a valid bit.
// Only the valid bit is reset or cleared; data simply holds when not enabled.
module register_pipe_stage
    import register_pipe_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/register_pipe_ctrl.sv
// Valid/ready controller for a chain of STAGES register stages with bubble collapsing.
// Define REGISTER_PIPE_CTRL_STATS_EN to add the stall_cycles statistics port.
module register_pipe_ctrl
    import register_pipe_ctrl_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int CNT_W  = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WIDTH-1:0]  s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WIDTH-1:0]  m_data,
    output logic [STAGES-1:0] stage_en,
    output logic [CNT_W-1:0]  occupancy,
    output logic              idle
`ifdef REGISTER_PIPE_CTRL_STATS_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    generate
        if (STAGES < MIN_STAGES) begin : g_bad_stages
            $error("register_pipe_ctrl: STAGES must be >= %0d", MIN_STAGES);
        end
    endgenerate

    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_advance;
    logic [STAGES-1:0] w_stage_en;
    logic [STAGES-1:0] w_src_valid;
    logic [WIDTH-1:0]  w_data     [STAGES];
    logic [WIDTH-1:0]  w_src_data [STAGES];
    logic              w_in_acc;
    logic              w_out_acc;
    occ_op_e           w_occ_op;
    logic [CNT_W-1:0]  r_occ;

    // A stage advances if it is empty or everything downstream of it can move.
    always_comb begin
        logic chain;
        chain     = m_ready;
        w_advance = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            chain        = chain || !w_valid[i];
            w_advance[i] = chain;
        end
    end

    assign w_stage_en = w_advance & {STAGES{!flush}};
    assign stage_en   = w_stage_en;
    assign s_ready    = w_advance[0] && !flush;

    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            if (i == 0) begin : g_head
                assign w_src_valid[i] = s_valid;
                assign w_src_data[i]  = s_data;
            end else begin : g_body
                assign w_src_valid[i] = w_valid[i-1];
                assign w_src_data[i]  = w_data[i-1];
            end

            register_pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .i_en    (w_stage_en[i]),
                .i_clr   (flush),
                .i_valid (w_src_valid[i]),
                .i_data  (w_src_data[i]),
                .o_valid (w_valid[i]),
                .o_data  (w_data[i])
            );
        end
    endgenerate

    assign m_valid = w_valid[STAGES-1];
    assign m_data  = w_data[STAGES-1];

    assign w_in_acc  = s_valid && s_ready;
    assign w_out_acc = m_valid && m_ready;
    assign w_occ_op  = occ_op(w_in_acc, w_out_acc);

    // Flush empties every stage, so the count drops to zero regardless of accepts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            case (w_occ_op)
                OCC_INC: r_occ <= r_occ + CNT_W'(1);
                OCC_DEC: r_occ <= r_occ - CNT_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign occupancy = r_occ;
    assign idle      = (r_occ == '0);

`ifdef REGISTER_PIPE_CTRL_STATS_EN
    logic [31:0] r_stall_cycles;

    // Saturating consumer-stall counter; only reset clears it, flush does not.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cycles <= '0;
        end else if (m_valid && !m_ready && (r_stall_cycles != STALL_MAX)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_register_pipe_ctrl.sv
// Scoreboard bench for register_pipe_ctrl (STAGES = 4, WIDTH = 16).
// Stall statistics checks run only when REGISTER_PIPE_CTRL_STATS_EN is defined.
module tb_register_pipe_ctrl;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              s_valid;
    logic              s_ready;
    logic [WIDTH-1:0]  s_data;
    logic              m_valid;
    logic              m_ready;
    logic [WIDTH-1:0]  m_data;
    logic [STAGES-1:0] stage_en;
    logic [CNT_W-1:0]  occupancy;
    logic              idle;
`ifdef REGISTER_PIPE_CTRL_STATS_EN
    logic [31:0]       stall_cycles;
`endif

    int nCompared   = 0;
    int nMismatched = 0;
    logic [WIDTH-1:0] expQ [$];

    register_pipe_ctrl #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .stage_en     (stage_en),
        .occupancy    (occupancy),
        .idle         (idle)
`ifdef REGISTER_PIPE_CTRL_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic sv, input logic [WIDTH-1:0] d,
                                 input logic mr, input logic fl);
        s_valid = sv;
        s_data  = d;
        m_ready = mr;
        flush   = fl;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Pops one expected beat for every output handshake the DUT completes.
    always @(negedge clk) begin
        if (reset && m_valid && m_ready) begin
            nCompared++;
            if (expQ.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL sb_unexpected: got beat 0x%0h, expected none", m_data);
            end else begin
                logic [WIDTH-1:0] exp;
                exp = expQ.pop_front();
                if (m_data !== exp) begin
                    nMismatched++;
                    $display("[TB] FAIL sb_data: got 0x%0h, expected 0x%0h", m_data, exp);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rst_m_valid",  32'(m_valid),   32'd0);
        checkOutput("rst_occ",      32'(occupancy), 32'd0);
        checkOutput("rst_idle",     32'(idle),      32'd1);
        checkOutput("rst_s_ready",  32'(s_ready),   32'd1);
        checkOutput("rst_stage_en", 32'(stage_en),  32'hF);
`ifdef REGISTER_PIPE_CTRL_STATS_EN
        checkOutput("rst_stall",    stall_cycles,   32'd0);
`endif
        cycle();

        $display("[TB] stream 1..8 with m_ready high");
        for (int k = 1; k <= 8; k++) expQ.push_back(WIDTH'(k));
        for (int k = 0; k < 13; k++) begin
            applyStimulus(k < 8, (k < 8) ? WIDTH'(k + 1) : '0, 1'b1, 1'b0);
            checkOutput("stream_m_valid", 32'(m_valid), 32'((k >= 4) && (k < 12)));
            checkOutput("stream_occ", 32'(occupancy), (k <= 8) ? ((k < 4) ? 32'(k) : 32'd4) : 32'(12 - k));
            cycle();
        end

        $display("[TB] backpressure fill and release");
        for (int k = 0; k < 5; k++) expQ.push_back(WIDTH'(16'h11 + k));
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, WIDTH'(16'h11 + k), 1'b0, 1'b0);
            checkOutput("bp_fill_s_ready", 32'(s_ready), 32'd1);
            cycle();
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 16'h15, 1'b0, 1'b0);
            checkOutput("bp_full_s_ready",  32'(s_ready),   32'd0);
            checkOutput("bp_full_occ",      32'(occupancy), 32'd4);
            checkOutput("bp_full_stage_en", 32'(stage_en),  32'd0);
            checkOutput("bp_full_m_data",   32'(m_data),    32'h11);
            cycle();
        end
        applyStimulus(1'b1, 16'h15, 1'b1, 1'b0);
        checkOutput("bp_release_s_ready",  32'(s_ready),  32'd1);
        checkOutput("bp_release_stage_en", 32'(stage_en), 32'hF);
        cycle();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            cycle();
        end
        checkOutput("bp_drain_idle", 32'(idle), 32'd1);

        $display("[TB] bubble collapse");
        expQ.push_back(16'h000A);
        expQ.push_back(16'h000B);
        applyStimulus(1'b1, 16'h000A, 1'b0, 1'b0); cycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);       cycle();
        cycle();
        applyStimulus(1'b1, 16'h000B, 1'b0, 1'b0); cycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);       cycle();
        cycle();
        checkOutput("bub_occ",      32'(occupancy), 32'd2);
        checkOutput("bub_stage_en", 32'(stage_en),  32'b0011);
        checkOutput("bub_m_data",   32'(m_data),    32'h000A);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("bub_first_valid", 32'(m_valid), 32'd1);
        cycle();
        checkOutput("bub_second_valid", 32'(m_valid), 32'd1);
        checkOutput("bub_second_data",  32'(m_data),  32'h000B);
        cycle();
        checkOutput("bub_idle", 32'(idle), 32'd1);

        $display("[TB] simultaneous accept");
        expQ.push_back(16'h21);
        expQ.push_back(16'h22);
        expQ.push_back(16'h23);
        applyStimulus(1'b1, 16'h21, 1'b0, 1'b0); cycle();
        applyStimulus(1'b1, 16'h22, 1'b0, 1'b0); cycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);     cycle();
        cycle();
        applyStimulus(1'b1, 16'h23, 1'b1, 1'b0);
        checkOutput("sim_occ_before", 32'(occupancy), 32'd2);
        checkOutput("sim_s_ready",    32'(s_ready),   32'd1);
        checkOutput("sim_m_valid",    32'(m_valid),   32'd1);
        cycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("sim_occ_after", 32'(occupancy), 32'd2);
        repeat (4) cycle();
        checkOutput("sim_drain_idle", 32'(idle), 32'd1);

        $display("[TB] flush at occupancy 3");
        applyStimulus(1'b1, 16'h31, 1'b0, 1'b0); cycle();
        applyStimulus(1'b1, 16'h32, 1'b0, 1'b0); cycle();
        applyStimulus(1'b1, 16'h33, 1'b0, 1'b0); cycle();
        applyStimulus(1'b1, 16'h34, 1'b0, 1'b1);
        checkOutput("fl_occ_before", 32'(occupancy), 32'd3);
        checkOutput("fl_s_ready",    32'(s_ready),   32'd0);
        checkOutput("fl_stage_en",   32'(stage_en),  32'd0);
        cycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("fl_m_valid", 32'(m_valid),   32'd0);
        checkOutput("fl_occ",     32'(occupancy), 32'd0);
        checkOutput("fl_idle",    32'(idle),      32'd1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            checkOutput("fl_no_late_beat", 32'(m_valid), 32'd0);
        end

        $display("[TB] reset mid-transfer");
        applyStimulus(1'b1, 16'h51, 1'b0, 1'b0); cycle();
        reset = 1'b0;
        applyStimulus(1'b1, 16'h52, 1'b0, 1'b0); cycle();
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("mid_rst_occ",     32'(occupancy), 32'd0);
        checkOutput("mid_rst_m_valid", 32'(m_valid),   32'd0);
        checkOutput("mid_rst_idle",    32'(idle),      32'd1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            checkOutput("mid_rst_empty", 32'(m_valid), 32'd0);
        end

`ifdef REGISTER_PIPE_CTRL_STATS_EN
        $display("[TB] stall statistics");
        checkOutput("st_start", stall_cycles, 32'd0);
        expQ.push_back(16'h41);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, WIDTH'(16'h41 + k), 1'b0, 1'b0);
            cycle();
        end
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
            checkOutput("st_held_valid", 32'(m_valid), 32'd1);
            cycle();
        end
        checkOutput("st_count10", stall_cycles, 32'd10);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        cycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("st_after_flush", stall_cycles,     32'd10);
        checkOutput("st_flush_occ",   32'(occupancy),   32'd0);
        checkOutput("st_flush_valid", 32'(m_valid),     32'd0);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        #1;
        checkOutput("st_after_reset", stall_cycles, 32'd0);
`endif

        cycle();
        checkOutput("sb_all_consumed", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
